// File: rtl/mult_share_arb.sv
// mult_share_arb
// Round-robin arbiter and sequencer that lets two requesters share one
// external signed WIDTH x WIDTH multiplier. One operand pair is in flight at
// a time: it is accepted in IDLE, held on mul_a/mul_b for MUL_LAT settle
// cycles in CALC, captured, and then presented on the owner's response
// channel in RESP until that requester takes it.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   reqN_valid/a/b/ready  operand request channel N (N = 0, 1), signed operands
//   rspN_valid/p/ready    product response channel N, 2*WIDTH signed product
//   mul_a, mul_b          registered operands to the shared multiplier
//   mul_p                 combinational product from the shared multiplier
//   busy                  high whenever a transaction is in progress
module mult_share_arb #(
   parameter int WIDTH   = 4,
   parameter int MUL_LAT = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        req0_valid,
   input  logic signed [WIDTH-1:0]     req0_a,
   input  logic signed [WIDTH-1:0]     req0_b,
   output logic                        req0_ready,
   input  logic                        req1_valid,
   input  logic signed [WIDTH-1:0]     req1_a,
   input  logic signed [WIDTH-1:0]     req1_b,
   output logic                        req1_ready,
   output logic                        rsp0_valid,
   output logic signed [2*WIDTH-1:0]   rsp0_p,
   input  logic                        rsp0_ready,
   output logic                        rsp1_valid,
   output logic signed [2*WIDTH-1:0]   rsp1_p,
   input  logic                        rsp1_ready,
   output logic signed [WIDTH-1:0]     mul_a,
   output logic signed [WIDTH-1:0]     mul_b,
   input  logic signed [2*WIDTH-1:0]   mul_p,
   output logic                        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] LAT_INIT = 4'(MUL_LAT);

   state_t                     state_q,   state_d;
   logic                       last_gnt_q, last_gnt_d;
   logic                       owner_q,   owner_d;
   logic [3:0]                 cnt_q,     cnt_d;
   logic signed [WIDTH-1:0]    mul_a_q,   mul_a_d;
   logic signed [WIDTH-1:0]    mul_b_q,   mul_b_d;
   logic signed [2*WIDTH-1:0]  result_q,  result_d;
   logic signed [2*WIDTH-1:0]  rsp0_p_q,  rsp0_p_d;
   logic signed [2*WIDTH-1:0]  rsp1_p_q,  rsp1_p_d;

   logic gnt_any;
   logic gnt_id;
   logic owner_ready;

   // Arbitration: a lone requester wins outright; on a tie the requester
   // that did not win last time is chosen.
   always_comb begin
      gnt_any = req0_valid | req1_valid;
      if (req0_valid && req1_valid) begin
         gnt_id = ~last_gnt_q;
      end else begin
         gnt_id = req1_valid;
      end
      owner_ready = owner_q ? rsp1_ready : rsp0_ready;
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         last_gnt_q <= 1'b1;
         owner_q    <= 1'b0;
         cnt_q      <= '0;
         mul_a_q    <= '0;
         mul_b_q    <= '0;
         result_q   <= '0;
         rsp0_p_q   <= '0;
         rsp1_p_q   <= '0;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
         owner_q    <= owner_d;
         cnt_q      <= cnt_d;
         mul_a_q    <= mul_a_d;
         mul_b_q    <= mul_b_d;
         result_q   <= result_d;
         rsp0_p_q   <= rsp0_p_d;
         rsp1_p_q   <= rsp1_p_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
      owner_d    = owner_q;
      cnt_d      = cnt_q;
      mul_a_d    = mul_a_q;
      mul_b_d    = mul_b_q;
      result_d   = result_q;
      rsp0_p_d   = rsp0_p_q;
      rsp1_p_d   = rsp1_p_q;
      case (state_q)
         IDLE: begin
            if (gnt_any) begin
               state_d    = CALC;
               owner_d    = gnt_id;
               last_gnt_d = gnt_id;
               cnt_d      = LAT_INIT;
               mul_a_d    = gnt_id ? req1_a : req0_a;
               mul_b_d    = gnt_id ? req1_b : req0_b;
            end
         end
         CALC: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               result_d = mul_p;
               state_d  = RESP;
            end
         end
         RESP: begin
            // The owner's visible product is committed to its holding
            // register on completion so it persists after valid drops.
            if (owner_ready) begin
               state_d = IDLE;
               if (owner_q) begin
                  rsp1_p_d = result_q;
               end else begin
                  rsp0_p_d = result_q;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs
   always_comb begin
      req0_ready = (state_q == IDLE) && gnt_any && !gnt_id;
      req1_ready = (state_q == IDLE) && gnt_any &&  gnt_id;
      rsp0_valid = (state_q == RESP) && !owner_q;
      rsp1_valid = (state_q == RESP) &&  owner_q;
      rsp0_p     = rsp0_valid ? result_q : rsp0_p_q;
      rsp1_p     = rsp1_valid ? result_q : rsp1_p_q;
      mul_a      = mul_a_q;
      mul_b      = mul_b_q;
      busy       = (state_q != IDLE);
   end

endmodule

// File: doc/mult_share_arb.md
Name: mult_share_arb

Overview:
Round-robin arbiter and sequencer that shares one signed 4x4 multiplier datapath between two requesters. The datapath has the BoothMult port contract: operands a/b in, 8-bit two's-complement product p out.
The block accepts one operand pair at a time over a valid/ready handshake. It drives the shared multiplier for a fixed settle time, captures the product and returns it on the winning requester's response channel. It sits between client logic and the multiplier instance; the multiplier is external and connects via the mul_* ports.

Parameters:
WIDTH, 4, operand width; product width is 2*WIDTH
MUL_LAT, 1, cycles the product is allowed to settle before capture; legal range 1..15

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous reset, active-low
req0_valid  in  1  requester 0 has an operand pair
req0_a  in  WIDTH  requester 0 multiplicand (signed)
req0_b  in  WIDTH  requester 0 multiplier (signed)
req0_ready  out  1  requester 0 pair accepted this cycle
req1_valid / req1_a / req1_b / req1_ready  same as above, requester 1
rsp0_valid  out  1  product for requester 0 available
rsp0_p  out  2*WIDTH  product for requester 0
rsp0_ready  in  1  requester 0 takes product
rsp1_valid / rsp1_p / rsp1_ready  same as above, requester 1
mul_a  out  WIDTH  operand to shared multiplier (registered)
mul_b  out  WIDTH  operand to shared multiplier (registered)
mul_p  in  2*WIDTH  product from shared multiplier (combinational)
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset values, applied on a clk edge with rst_n=0:
  - state=IDLE, last_gnt=1 (requester 0 wins the first tie), cnt=0
  - mul_a=0, mul_b=0, result reg=0
  - rsp0_valid=0, rsp1_valid=0, rsp0_p=0, rsp1_p=0, busy=0
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - Grant is combinational:
    - only reqN_valid high -> grant N
    - both high -> grant the requester not equal to last_gnt
  - reqN_ready = (state==IDLE) & grant==N; the other ready is 0.
  - req*_ready are 0 in CALC and RESP.
  - On accept edge:
    - mul_a<=reqN_a, mul_b<=reqN_b
    - owner<=N, last_gnt<=N, cnt<=MUL_LAT
    - next state CALC
- CALC:
  - mul_a/mul_b held stable; cnt decrements each cycle.
  - In the cycle cnt==1: result<=mul_p, next state RESP.
- RESP:
  - rsp[owner]_valid=1 and rsp[owner]_p=result; the other channel's valid is 0.
  - Held until rsp[owner]_ready=1 at an edge, then state IDLE.
  - rsp valid is never dropped without ready.
- Latency: accept in cycle T -> rspN_valid high from cycle T+1+MUL_LAT.
- Throughput: one product per MUL_LAT+2 cycles with ready held high; no overlap of transactions.
- rspN_p retains its last captured value when rspN_valid=0; only the owner's rsp_p updates.
- Operands and product are two's complement. No overflow is possible: the full 2*WIDTH product is captured unchanged from mul_p.
- A new request arriving during CALC/RESP waits; reqN_valid must stay asserted with stable operands until ready.
- Same-cycle rspN_ready and reqN_valid: the response completes this edge; the new request is arbitrated in the next IDLE cycle (one bubble cycle).
- rst_n low mid-CALC or mid-RESP: transaction discarded, no response issued, all registers to reset values on that edge.
- mul_a/mul_b keep their last values in IDLE/RESP. They change only on an accept edge.

Test Plan:
- Reset then idle: rst_n=0 two cycles -> all rsp_valid=0, mul_a=mul_b=0, busy=0, req0_ready=req1_ready=0 with no valid.
- Single requester, MUL_LAT=1, behavioural signed multiplier on mul_*:
  - req0 a=0010 b=0010 accepted cycle T -> rsp0_valid at T+2, rsp0_p=00000100.
  - rsp1_valid stays 0.
- Signed operands: req1 a=1010 b=1001 -> rsp1_p=00101010 (+42); req0 a=0100 b=1000 -> rsp0_p=11100000 (-32).
- Simultaneous valid from both after reset:
  - req0 granted first, req1 next, then req0 again (alternation over 4 transactions).
  - No lost or duplicated product.
- Response backpressure: rsp0_ready held 0 for 5 cycles -> rsp0_valid and rsp0_p stable, busy=1, req1_ready=0 throughout; release -> req1 accepted in the following IDLE cycle.
- Reset mid-CALC with MUL_LAT=3: rst_n=0 on cycle 2 of CALC -> no rsp_valid ever asserted for that transaction; next request completes normally with a correct product.
